// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, one bit per clock).
// Define FAST_MULT_EN to use a single-cycle combinational product for MULT/MULTU.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b;
    logic [DW-1:0]    r_acc;
    logic             r_neg_q, r_neg_r;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] r_hi, r_lo;

    // Operand decode for the start cycle
    logic             w_is_div, w_rs_neg, w_rt_neg, w_dz;
    logic [WIDTH-1:0] w_rs_mag, w_rt_mag;

    assign w_is_div = op[1];
    assign w_rs_neg = !op[0] && rs_data[WIDTH-1];
    assign w_rt_neg = !op[0] && rt_data[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? WIDTH'(-rs_data) : rs_data;
    assign w_rt_mag = w_rt_neg ? WIDTH'(-rt_data) : rt_data;
    assign w_dz     = w_is_div && (rt_data == {WIDTH{1'b0}});

`ifdef FAST_MULT_EN
    logic [DW-1:0] w_fast_prod;
    assign w_fast_prod = DW'(w_rs_mag) * DW'(w_rt_mag);
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_mul_sum, w_div_sh, w_div_diff;
    logic [DW-1:0]    w_mul_nxt, w_div_nxt, w_step;

    assign w_addend   = r_acc[0] ? r_b : {WIDTH{1'b0}};
    assign w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_nxt  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_div_sh   = r_acc[DW-1:WIDTH-1];
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_nxt  = w_div_diff[WIDTH] ? {r_acc[DW-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_step     = r_op[1] ? w_div_nxt : w_mul_nxt;

    // Sign correction applied in FIN
    logic [DW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_q, w_r, w_hi_fin, w_lo_fin;

    assign w_prod_fix = r_neg_q ? DW'(-r_acc) : r_acc;
    assign w_q        = r_acc[WIDTH-1:0];
    assign w_r        = r_acc[DW-1:WIDTH];
    assign w_hi_fin   = r_op[1] ? (r_neg_r ? WIDTH'(-w_r) : w_r) : w_prod_fix[DW-1:WIDTH];
    assign w_lo_fin   = r_op[1] ? (r_neg_q ? WIDTH'(-w_q) : w_q) : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef FAST_MULT_EN
                    w_state_nxt = w_is_div ? S_RUN : S_FIN;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        if (w_is_div) begin
                            // Zero divisor: raw dividend shifts through to HI untouched
                            r_b     <= w_rt_mag;
                            r_acc   <= {{WIDTH{1'b0}}, (w_dz ? rs_data : w_rs_mag)};
                            r_neg_q <= !w_dz && (w_rs_neg != w_rt_neg);
                            r_neg_r <= !w_dz && w_rs_neg;
                        end else begin
                            r_b     <= w_rs_mag;
`ifdef FAST_MULT_EN
                            r_acc   <= w_fast_prod;
`else
                            r_acc   <= {{WIDTH{1'b0}}, w_rt_mag};
`endif
                            r_neg_q <= (w_rs_neg != w_rt_neg);
                            r_neg_r <= 1'b0;
                        end
                    end else begin
                        if (hi_wr) r_hi <= wr_data;
                        if (lo_wr) r_lo <= wr_data;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIN: begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit against an arithmetic reference model.
// Honours FAST_MULT_EN for the expected multiply latency.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_wr, lo_wr;
    logic [1:0]   op;
    logic [W-1:0] rs_data, rt_data, wr_data;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_wr   (hi_wr),
        .lo_wr   (lo_wr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: 64-bit products, truncating division
    function automatic void ref_model(input logic [1:0] f_op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r_hi, output logic [W-1:0] r_lo);
        longint       sa, sb;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f_op)
            2'b00: begin p = 64'(sa * sb); r_hi = p[63:32]; r_lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; r_hi = p[63:32]; r_lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin r_hi = a; r_lo = '1; end
                else begin r_lo = W'(sa / sb); r_hi = W'(sa % sb); end
            end
            default: begin
                if (b == 0) begin r_hi = a; r_lo = '1; end
                else begin r_lo = a / b; r_hi = a % b; end
            end
        endcase
    endfunction

    function automatic int lat_exp(input logic [1:0] f_op);
`ifdef FAST_MULT_EN
        if (!f_op[1]) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic wr_with_start, input int poke);
        logic [W-1:0] eh, el, ph, pl;
        int cyc, hold_bad, busy_bad;
        ref_model(o, a, b, eh, el);
        ph = hi; pl = lo;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        hi_wr = wr_with_start; lo_wr = wr_with_start; wr_data = W'($urandom);
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        rs_data = W'($urandom); rt_data = W'($urandom);
        cyc = 0; hold_bad = 0; busy_bad = 0;
        while (!done && cyc < 100) begin
            if (hi !== ph || lo !== pl) hold_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (cyc == poke) begin
                start = 1'b1; op = 2'($urandom); rs_data = W'($urandom); rt_data = W'($urandom);
                hi_wr = 1'b1; lo_wr = 1'b1; wr_data = W'($urandom);
            end else begin
                start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        chk({tag, "_lat"},  W'(cyc), W'(lat_exp(o)));
        chk({tag, "_hi"},   hi, eh);
        chk({tag, "_lo"},   lo, el);
        chk({tag, "_busy"}, W'(busy), W'(0));
        chk({tag, "_hold"}, W'(hold_bad), W'(0));
        chk({tag, "_bsy"},  W'(busy_bad), W'(0));
        @(negedge clk);
        chk({tag, "_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        logic [1:0] ro;
        rst = 1'b1; start = 1'b0; op = '0; hi_wr = 1'b0; lo_wr = 1'b0;
        rs_data = '0; rt_data = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // MTHI alone, then MTHI+MTLO together
        hi_wr = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clk);
        hi_wr = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, '0);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("mthilo_hi", hi, 32'hCAFE_F00D);
        chk("mthilo_lo", lo, 32'hCAFE_F00D);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, -1);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_op("divu_z",    2'b11, 32'd7, 32'd0, 1'b0, -1);
        run_op("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, -1);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("divu_100",  2'b11, 32'd100, 32'd7, 1'b0, -1);
        run_op("mult_5x6",  2'b00, 32'd5, 32'd6, 1'b0, -1);
        run_op("divu_9_3",  2'b11, 32'd9, 32'd3, 1'b0, -1);
        run_op("wr_start",  2'b10, 32'd100, 32'hFFFF_FFF7, 1'b1, -1);
`ifdef FAST_MULT_EN
        run_op("poke",      2'b11, 32'd12, 32'd1, 1'b0, 5);
`else
        run_op("poke",      2'b01, 32'd3, 32'd4, 1'b0, 5);
`endif

        // Reset in the middle of an operation
        start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 2'b10, 32'hFFFF_FF00, 32'd7, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            run_op($sformatf("rnd%0d", i), ro, pick(), pick(), 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
